// File: rtl/imc_sequencer.sv
// IMC instruction sequencer: buffers instructions in a small FIFO and expands each one
// into a multi-cycle command sequence for the memristive array controller.
module imc_sequencer #(
    parameter int INSTRUCTION_SIZE = 32,
    parameter int DATA_MEM_SIZE    = 16,
    parameter int ADDR_MEM_SIZE    = 4,
    parameter int INSTR_DEPTH      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              instr_valid,
    output logic                              instr_ready,
    input  logic [INSTRUCTION_SIZE-1:0]       instruction,
    output logic                              CS,
    output logic                              WE,
    output logic                              OE,
    output logic [ADDR_MEM_SIZE-1:0]          ADDR_MEM1,
    output logic [ADDR_MEM_SIZE-1:0]          ADDR_MEM2,
    output logic [ADDR_MEM_SIZE-1:0]          ADDR_MEM3,
    output logic [DATA_MEM_SIZE-1:0]          DATA_TO_MEM,
    input  logic [DATA_MEM_SIZE-1:0]          DATA_FROM_MEM,
    output logic [DATA_MEM_SIZE-1:0]          SAEN,
    output logic                              EXECUTE_MIG,
    output logic                              EXECUTE_MAGIC,
    output logic                              EXECUTE_IMPLY,
    output logic                              EXECUTE_BITWISE,
    output logic [1:0]                        exec_logical_bitwise,
    output logic [DATA_MEM_SIZE-1:0]          rd_data,
    output logic                              rd_valid,
    output logic                              op_done,
    output logic                              busy,
    output logic [2:0]                        dbg_state_o,
    output logic [$clog2(INSTR_DEPTH):0]      dbg_count_o
);

    localparam int W  = INSTRUCTION_SIZE;
    localparam int D  = DATA_MEM_SIZE;
    localparam int A  = ADDR_MEM_SIZE;
    localparam int PW = $clog2(INSTR_DEPTH);
    localparam int CW = PW + 1;

    localparam int F1_HI = W - 4;
    localparam int F2_HI = W - 4 - A;
    localparam int F3_HI = W - 4 - 2 * A;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4;

    localparam logic [1:0] OP_MIG   = 2'b00;
    localparam logic [1:0] OP_MAGIC = 2'b01;
    localparam logic [1:0] OP_IMPLY = 2'b10;

    // Handshake: a word is accepted on a rising edge where instr_valid && instr_ready.
    // instr_ready depends only on the stored count, so a pop in the same cycle never
    // reopens a full FIFO.
    logic [W-1:0]  fifo_mem_q [INSTR_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop;
    logic [W-1:0]  head;

    logic [2:0]    state_q, state_d;
    logic [W-1:0]  instr_q, instr_d;

    logic          cs_q, cs_d, we_q, we_d, oe_q, oe_d;
    logic [A-1:0]  addr1_q, addr1_d, addr2_q, addr2_d, addr3_q, addr3_d;
    logic [D-1:0]  dout_q, dout_d;
    logic [D-1:0]  saen_q, saen_d;
    logic          ex_mig_q, ex_mig_d, ex_magic_q, ex_magic_d;
    logic          ex_imply_q, ex_imply_d, ex_bw_q, ex_bw_d;
    logic [1:0]    func_q, func_d;
    logic [D-1:0]  rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          op_done_q, op_done_d;

    logic [W-1:0]  cur;
    logic [1:0]    op;
    logic          sub;
    logic [A-1:0]  f1, f2, f3;
    logic [D-1:0]  data_f;
    logic [1:0]    func;
    logic          unused_instr_bits;

    assign instr_ready = (count_q != CW'(INSTR_DEPTH));
    assign push        = instr_valid && instr_ready;
    assign pop         = (state_q == S_IDLE) && (count_q != '0);
    assign head        = fifo_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= instruction;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // In IDLE the op being launched is still at the FIFO head; afterwards it lives in instr_q.
    assign cur    = (state_q == S_IDLE) ? head : instr_q;
    assign op     = cur[W-1 -: 2];
    assign sub    = cur[W-3];
    assign f1     = cur[F1_HI -: A];
    assign f2     = cur[F2_HI -: A];
    assign f3     = cur[F3_HI -: A];
    assign data_f = cur[F2_HI -: D];
    assign func   = cur[1:0];
    assign unused_instr_bits = ^cur;

    // Next-cycle command values; every output is a register loaded from these.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        cs_d       = 1'b1;
        we_d       = 1'b1;
        oe_d       = 1'b1;
        saen_d     = '0;
        addr1_d    = addr1_q;
        addr2_d    = addr2_q;
        addr3_d    = addr3_q;
        dout_d     = dout_q;
        ex_mig_d   = 1'b0;
        ex_magic_d = 1'b0;
        ex_imply_d = 1'b0;
        ex_bw_d    = 1'b0;
        func_d     = 2'b00;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        op_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    instr_d = head;
                    case (op)
                        OP_MIG: begin
                            ex_mig_d = 1'b1;
                            addr1_d  = f1;
                            if (sub) begin
                                state_d   = S_WR;
                                cs_d      = 1'b0;
                                we_d      = 1'b0;
                                dout_d    = data_f;
                                op_done_d = 1'b1;
                            end else begin
                                state_d = S_RD;
                                cs_d    = 1'b0;
                                oe_d    = 1'b0;
                                saen_d  = '1;
                            end
                        end
                        OP_MAGIC: begin
                            state_d    = S_EXEC;
                            ex_magic_d = 1'b1;
                            cs_d       = 1'b0;
                            we_d       = 1'b0;
                            addr1_d    = f1;
                            addr2_d    = f2;
                            addr3_d    = f3;
                            op_done_d  = 1'b1;
                        end
                        OP_IMPLY: begin
                            state_d    = S_RD;
                            ex_imply_d = 1'b1;
                            cs_d       = 1'b0;
                            oe_d       = 1'b0;
                            saen_d     = '1;
                            addr1_d    = f1;
                            if (!sub) begin
                                addr2_d = f2;
                            end
                        end
                        default: begin
                            state_d = S_RD;
                            ex_bw_d = 1'b1;
                            func_d  = func;
                            cs_d    = 1'b0;
                            oe_d    = 1'b0;
                            saen_d  = '1;
                            addr1_d = f1;
                            addr2_d = f2;
                        end
                    endcase
                end
            end

            S_RD: begin
                case (op)
                    OP_MIG: begin
                        state_d  = S_WAIT;
                        ex_mig_d = 1'b1;
                    end
                    OP_IMPLY: begin
                        ex_imply_d = 1'b1;
                        if (sub) begin
                            state_d = S_WAIT;
                        end else begin
                            state_d   = S_WR;
                            cs_d      = 1'b0;
                            we_d      = 1'b0;
                            addr2_d   = f2;
                            op_done_d = 1'b1;
                        end
                    end
                    OP_MAGIC: begin
                        state_d = S_IDLE;
                    end
                    default: begin
                        state_d = S_WAIT;
                        ex_bw_d = 1'b1;
                        func_d  = func;
                    end
                endcase
            end

            // Read data is valid during WAIT and is captured on the edge that ends it.
            S_WAIT: begin
                case (op)
                    OP_MIG: begin
                        state_d    = S_IDLE;
                        rd_data_d  = DATA_FROM_MEM;
                        rd_valid_d = 1'b1;
                        op_done_d  = 1'b1;
                    end
                    OP_IMPLY: begin
                        state_d    = S_WR;
                        ex_imply_d = 1'b1;
                        cs_d       = 1'b0;
                        we_d       = 1'b0;
                        addr3_d    = f2;
                        dout_d     = DATA_FROM_MEM;
                        op_done_d  = 1'b1;
                    end
                    OP_MAGIC: begin
                        state_d = S_IDLE;
                    end
                    default: begin
                        state_d   = S_WR;
                        ex_bw_d   = 1'b1;
                        func_d    = func;
                        cs_d      = 1'b0;
                        we_d      = 1'b0;
                        addr3_d   = f3;
                        dout_d    = DATA_FROM_MEM;
                        op_done_d = 1'b1;
                    end
                endcase
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            cs_q       <= 1'b1;
            we_q       <= 1'b1;
            oe_q       <= 1'b1;
            addr1_q    <= '0;
            addr2_q    <= '0;
            addr3_q    <= '0;
            dout_q     <= '0;
            saen_q     <= '0;
            ex_mig_q   <= 1'b0;
            ex_magic_q <= 1'b0;
            ex_imply_q <= 1'b0;
            ex_bw_q    <= 1'b0;
            func_q     <= 2'b00;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            op_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            oe_q       <= oe_d;
            addr1_q    <= addr1_d;
            addr2_q    <= addr2_d;
            addr3_q    <= addr3_d;
            dout_q     <= dout_d;
            saen_q     <= saen_d;
            ex_mig_q   <= ex_mig_d;
            ex_magic_q <= ex_magic_d;
            ex_imply_q <= ex_imply_d;
            ex_bw_q    <= ex_bw_d;
            func_q     <= func_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            op_done_q  <= op_done_d;
        end
    end

    assign CS                   = cs_q;
    assign WE                   = we_q;
    assign OE                   = oe_q;
    assign ADDR_MEM1            = addr1_q;
    assign ADDR_MEM2            = addr2_q;
    assign ADDR_MEM3            = addr3_q;
    assign DATA_TO_MEM          = dout_q;
    assign SAEN                 = saen_q;
    assign EXECUTE_MIG          = ex_mig_q;
    assign EXECUTE_MAGIC        = ex_magic_q;
    assign EXECUTE_IMPLY        = ex_imply_q;
    assign EXECUTE_BITWISE      = ex_bw_q;
    assign exec_logical_bitwise = func_q;
    assign rd_data              = rd_data_q;
    assign rd_valid             = rd_valid_q;
    assign op_done              = op_done_q;
    assign busy                 = (state_q != S_IDLE) || (count_q != '0);
    assign dbg_state_o          = state_q;
    assign dbg_count_o          = count_q;

endmodule
